// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

  function automatic int unsigned id_width(int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int unsigned cnt_width(int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last_owner+1 with wrap.
module rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdW    = 2
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdW-1:0]    last_owner,
  output logic              found,
  output logic [IdW-1:0]    index
);

  logic [IdW-1:0] cand;

  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand = IdW'((32'(last_owner) + k) % NumReq);
      if (!found && req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter for the write port of an async FIFO.
// Optional owner-idle grant revocation is enabled by defining FIFO_ARB_TIMEOUT_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MAX_BURST    = 4,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wen,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_wfull,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int unsigned ID_W  = id_width(NUM_REQ);
  localparam int unsigned CNT_W = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(MAX_BURST - 1);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] last_owner_q, last_owner_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic            accept;
  logic            timeout;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NumReq (NUM_REQ),
    .IdW    (ID_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_owner (last_owner_q),
    .found      (pick_found),
    .index      (pick_idx)
  );

  assign accept = (state_q == StGrant) && req_valid[owner_q] && !fifo_wfull;

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  // Only cycles where the owner could have sent but did not count as idle.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (state_q != StGrant || accept) begin
      idle_cnt_d = '0;
    end else if (!req_valid[owner_q] && !fifo_wfull) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
  end

  assign timeout = (state_q == StGrant) && (idle_cnt_d == IDLE_W'(IDLE_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) idle_cnt_q <= '0;
    else     idle_cnt_q <= idle_cnt_d;
  end
`else
  logic unused_idle_timeout;
  assign unused_idle_timeout = ^IDLE_TIMEOUT;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (accept) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        if ((accept && (req_last[owner_q] || beat_cnt_q == LastBeat)) || timeout) begin
          state_d      = StIdle;
          last_owner_d = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Zero-latency write path: ready/wen/data follow registered owner and the live inputs.
  always_comb begin
    req_ready  = '0;
    fifo_wen   = 1'b0;
    fifo_wdata = '0;
    if (state_q == StGrant) begin
      req_ready[owner_q] = !fifo_wfull;
      fifo_wen           = accept;
      if (accept) fifo_wdata = data_arr[owner_q];
    end
  end

  assign busy     = (state_q == StGrant);
  assign grant_id = owner_q;

endmodule
